// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the programmable clock divider.
// Optional feature macro used by the divider: CLKDIV_PCNT_EN (completed-period counter).
package clkdiv_pkg;
  localparam int MIN_DIV         = 2;
  localparam int CNT_W_DEF       = 16;
  localparam int DIV_DEFAULT_DEF = 18;
  localparam int PCNT_W_DEF      = 16;

  typedef logic [CNT_W_DEF-1:0] ratio_t;
endpackage

// File: rtl/clkdiv_ratio_reg.sv
// Ratio shadow registers: validates load requests, holds a pending ratio and
// promotes it to the active ratio on the counter wrap strobe.
module clkdiv_ratio_reg
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEFAULT_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             div_ld,
  input  logic [CNT_W-1:0] div_val,
  input  logic             wrap,
  output logic [CNT_W-1:0] n_active,
  output logic             div_ack,
  output logic             div_err
);

  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_vld;
  logic             r_ack;
  logic             r_err;

  logic w_val_ok;
  logic w_load;
  logic w_apply;

  assign w_val_ok = (div_val >= CNT_W'(MIN_DIV));
  assign w_load   = div_ld & w_val_ok;
  assign w_apply  = wrap & r_pend_vld;

  // A load coinciding with an apply re-arms pending with the new value.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_n        <= CNT_W'(DIV_DEFAULT);
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ack <= w_apply;
      r_err <= div_ld & ~w_val_ok;
      if (w_apply) begin
        r_n <= r_pend;
      end
      if (w_load) begin
        r_pend     <= div_val;
        r_pend_vld <= 1'b1;
      end else if (w_apply) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign n_active = r_n;
  assign div_ack  = r_ack;
  assign div_err  = r_err;

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider with registered clk_out and edge ticks.
// Define CLKDIV_PCNT_EN to add the completed-period counter output period_cnt.
module clk_divider_prog
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEFAULT_DEF,
  parameter int PCNT_W      = PCNT_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              en,
  input  logic              div_ld,
  input  logic [CNT_W-1:0]  div_val,
  output logic              div_ack,
  output logic              div_err,
  output logic              clk_out,
  output logic              tick_rise,
`ifdef CLKDIV_PCNT_EN
  output logic [PCNT_W-1:0] period_cnt,
`endif
  output logic              tick_fall
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_clk;
  logic             r_rise;
  logic             r_fall;

  logic [CNT_W-1:0] w_n;
  logic [CNT_W-1:0] w_low;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_last;
  logic             w_wrap;
  logic             w_hi_next;

  clkdiv_ratio_reg #(
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_ratio (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .div_ld   (div_ld),
    .div_val  (div_val),
    .wrap     (w_wrap),
    .n_active (w_n),
    .div_ack  (div_ack),
    .div_err  (div_err)
  );

  // Low phase is floor(N/2); odd ratios spend the extra cycle high.
  assign w_low      = w_n >> 1;
  assign w_last     = (r_cnt == (w_n - CNT_W'(1)));
  assign w_wrap     = en & w_last;
  assign w_cnt_next = w_last ? '0 : (r_cnt + CNT_W'(1));
  assign w_hi_next  = (w_cnt_next >= w_low);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (en) begin
      r_cnt  <= w_cnt_next;
      r_clk  <= w_hi_next;
      r_rise <= w_hi_next & ~r_clk;
      r_fall <= ~w_hi_next & r_clk;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end
  end

  assign clk_out   = r_clk;
  assign tick_rise = r_rise;
  assign tick_fall = r_fall;

`ifdef CLKDIV_PCNT_EN
  logic [PCNT_W-1:0] r_pcnt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
    end else if (w_wrap) begin
      r_pcnt <= r_pcnt + PCNT_W'(1);
    end
  end

  assign period_cnt = r_pcnt;
`else
  logic [PCNT_W-1:0] w_unused_pcnt;
  assign w_unused_pcnt = '0;
`endif

endmodule
